// File: rtl/multicycle_addsub_gatelevel_pkg.sv
// Package for the multi-cycle adder/subtractor.
// Holds the FSM state encoding, the operation-mode encoding and a small
// helper that tells whether a mode needs operand B inverted.
package multicycle_addsub_gatelevel_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Subtraction is a + ~b + 1: B is inverted and the initial carry is set.
  function automatic logic mode_inverts_b(input logic m);
    return (m != MODE_ADD);
  endfunction

endpackage

// File: rtl/multicycle_addsub_gatelevel_digit_adder.sv
// Gate-level building blocks for the digit adder.
//
// full_adder_cell: 1-bit full adder made of primitive gates.
//   a, b, cin -> sum, cout
//
// digit_adder_gatelevel: purely combinational DIGIT-bit ripple adder built
// from full_adder_cell instances.
//   a[DIGIT], b[DIGIT], cin -> sum[DIGIT], cout (carry out of the MSB),
//   c_msb (carry into the MSB, used for signed-overflow detection).

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (cx_a, ab_x, cin);
  or  g_o1 (cout, ab_a, cx_a);

endmodule

module digit_adder_gatelevel #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // carry[i] is the carry into bit i; carry[DIGIT] leaves the MSB.
  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_bit
      full_adder_cell u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .sum  (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign cout  = carry[DIGIT];
  assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/multicycle_addsub_gatelevel.sv
// Multi-cycle two's-complement adder/subtractor.
//
// Processes WIDTH-bit operands DIGIT bits per clock, least significant digit
// first, through a registered carry. N = WIDTH/DIGIT cycles per operation.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request; accepted in IDLE or DONE, ignored in RUN
//   mode      0 = add (a+b), 1 = subtract (a-b); latched with start
//   a, b      operands; latched with start
//   busy      high while an operation is running
//   done      one-cycle pulse when the result registers are updated
//   sum       result, held until the next completion
//   cout      carry out of the MSB (subtract: 1 = no borrow)
//   overflow  signed overflow
//   zero      sum == 0
module multicycle_addsub_gatelevel
  import multicycle_addsub_gatelevel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  // Guarded so a bad DIGIT reports the elaboration error below instead of
  // dividing by zero first.
  localparam int N     = (DIGIT < 1) ? 1 : (WIDTH / DIGIT);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1) begin : g_bad_digit
      $error("multicycle_addsub_gatelevel: DIGIT must be >= 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("multicycle_addsub_gatelevel: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               carry;
  logic [CNT_W-1:0]   count;

  logic [DIGIT-1:0]   digit_sum;
  logic               digit_cout;
  logic               digit_cmsb;
  logic [WIDTH-1:0]   res_shift;
  logic               last_digit;
  logic               inv_b;

  digit_adder_gatelevel #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .cin   (carry),
    .sum   (digit_sum),
    .cout  (digit_cout),
    .c_msb (digit_cmsb)
  );

  // The result register fills from the MSB side, so after N shifts the first
  // digit computed sits at the bottom. Built with a right shift plus a part
  // select on the top so that DIGIT == WIDTH needs no special case.
  always_comb begin
    res_shift                     = res_sr >> DIGIT;
    res_shift[WIDTH-1 -: DIGIT]   = digit_sum;
  end

  assign last_digit = (count == CNT_W'(N - 1));
  assign inv_b      = mode_inverts_b(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STATE_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
    end else begin
      unique case (state)
        STATE_IDLE, STATE_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{inv_b}};
            carry <= inv_b;
            count <= '0;
            state <= STATE_RUN;
            busy  <= 1'b1;
          end else begin
            state <= STATE_IDLE;
            busy  <= 1'b0;
          end
        end

        STATE_RUN: begin
          // start is deliberately not looked at here: no queueing, no restart.
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_shift;
          carry  <= digit_cout;
          count  <= count + CNT_W'(1);
          if (last_digit) begin
            state    <= STATE_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= res_shift;
            cout     <= digit_cout;
            // On the top digit the adder's internal MSB carry is the carry
            // into bit WIDTH-1 of the full word.
            overflow <= digit_cout ^ digit_cmsb;
            zero     <= (res_shift == '0);
          end else begin
            done <= 1'b0;
          end
        end

        default: begin
          state <= STATE_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_addsub_gatelevel.sv
module tb_multicycle_addsub_gatelevel;
  import multicycle_addsub_gatelevel_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  // m: 16/4, s: 16/1 (bit-serial), c: 16/16 (single cycle), w: 8/2
  logic        busy_m, done_m, cout_m, ov_m, zero_m;
  logic [15:0] sum_m;
  logic        busy_s, done_s, cout_s, ov_s, zero_s;
  logic [15:0] sum_s;
  logic        busy_c, done_c, cout_c, ov_c, zero_c;
  logic [15:0] sum_c;
  logic        busy_w, done_w, cout_w, ov_w, zero_w;
  logic [7:0]  sum_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_addsub_gatelevel #(.WIDTH(16), .DIGIT(4)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_m), .done(done_m), .sum(sum_m), .cout(cout_m),
    .overflow(ov_m), .zero(zero_m));

  multicycle_addsub_gatelevel #(.WIDTH(16), .DIGIT(1)) u_serial (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s),
    .overflow(ov_s), .zero(zero_s));

  multicycle_addsub_gatelevel #(.WIDTH(16), .DIGIT(16)) u_single (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy_c), .done(done_c), .sum(sum_c), .cout(cout_c),
    .overflow(ov_c), .zero(zero_c));

  multicycle_addsub_gatelevel #(.WIDTH(8), .DIGIT(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w),
    .overflow(ov_w), .zero(zero_w));

  // Arithmetic reference: returns {sum[15:0], cout, overflow, zero} for a
  // w-bit operation, computed from plain integer arithmetic.
  function automatic logic [18:0] model(input int w, input logic [15:0] x,
                                        input logic [15:0] y, input logic m);
    longint full, mask, xa, ya, r, sx, sy, sr;
    logic   c, o, z;
    logic [15:0] s;
    full = longint'(1) << w;
    mask = full - 1;
    xa   = longint'(x) & mask;
    ya   = longint'(y) & mask;
    r    = (m == MODE_SUB) ? (xa - ya) : (xa + ya);
    c    = (m == MODE_SUB) ? (xa >= ya) : (r >= full);
    s    = 16'(r & mask);
    sx   = (xa >= full / 2) ? xa - full : xa;
    sy   = (ya >= full / 2) ? ya - full : ya;
    sr   = (m == MODE_SUB) ? (sx - sy) : (sx + sy);
    o    = (sr >= full / 2) || (sr < -(full / 2));
    z    = (s == 16'h0);
    return {s, c, o, z};
  endfunction

  // Present an operation for one cycle. Returns at the negedge just after the
  // accepting edge, which is cycle 1 of the latency count.
  task automatic launch(input logic [15:0] xa, input logic [15:0] xb, input logic xm);
    @(negedge clk);
    a = xa; b = xb; mode = xm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs: the latched operands must be unaffected.
    a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
  endtask

  // Wait (bounded) for done on the 16/4 instance, counting negedges.
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done_m && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_m, done_m, sum_m, cout_m, ov_m, zero_m, busy_s, done_s, sum_s,
         busy_c, done_c, sum_c, busy_w, done_w, sum_w} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got m=%b%b%h%b%b%b, required all zero",
               busy_m, done_m, sum_m, cout_m, ov_m, zero_m);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy_m, done_m);
    end
    $display("test_reset: done");
  endtask

  task automatic test_add_basic;
    int cyc;
    int bad;
    launch(16'h1234, 16'h4321, MODE_ADD);
    bad = 0;
    for (cyc = 1; cyc <= 4; cyc++) begin
      if (busy_m !== 1'b1 || done_m !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL add_basic_busy: %0d cycles wrong, required busy=1 done=0 for 4 cycles", bad);
    end
    n_checks++;
    if (done_m !== 1'b1 || busy_m !== 1'b0 ||
        {sum_m, cout_m, ov_m, zero_m} !== {16'h5555, 3'b000}) begin
      n_fail++;
      $display("FAIL add_basic_result: done=%b busy=%b sum=%h c=%b v=%b z=%b, required 1 0 5555 0 0 0",
               done_m, busy_m, sum_m, cout_m, ov_m, zero_m);
    end
    @(negedge clk);
    n_checks++;
    if (done_m !== 1'b0 || sum_m !== 16'h5555) begin
      n_fail++;
      $display("FAIL add_basic_hold: done=%b sum=%h, required 0 5555", done_m, sum_m);
    end
    $display("test_add_basic: 1234+4321 -> %h", sum_m);
  endtask

  task automatic test_flags;
    logic [15:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        tm [4] = '{MODE_ADD, MODE_ADD, MODE_SUB, MODE_SUB};
    logic [18:0] te [4] = '{{16'h0000, 3'b101}, {16'h8000, 3'b010},
                            {16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], tm[i]);
      wait_done(1, cyc);
      n_checks++;
      if (cyc != 5 || {sum_m, cout_m, ov_m, zero_m} !== te[i]) begin
        n_fail++;
        $display("FAIL flags_%0d: cyc=%0d sum=%h cvz=%b%b%b, required cyc=5 sum=%h cvz=%b",
                 i, cyc, sum_m, cout_m, ov_m, zero_m, te[i][18:3], te[i][2:0]);
      end
      $display("test_flags: %h %s %h -> %h c=%b v=%b z=%b", ta[i],
               tm[i] ? "-" : "+", tb[i], sum_m, cout_m, ov_m, zero_m);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    launch(16'h1111, 16'h2222, MODE_ADD);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; mode = MODE_SUB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, cyc);
    n_checks++;
    if (cyc != 5 || {sum_m, cout_m, ov_m, zero_m} !== {16'h3333, 3'b000}) begin
      n_fail++;
      $display("FAIL ignore_start: cyc=%0d sum=%h, required cyc=5 sum=3333", cyc, sum_m);
    end
    @(negedge clk);
    n_checks++;
    if (busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start_no_restart: busy=%b, required 0", busy_m);
    end
    $display("test_ignore_start: result %h", sum_m);
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(16'h0100, 16'h0023, MODE_ADD);
    wait_done(1, cyc);
    n_checks++;
    if (cyc != 5 || sum_m !== 16'h0123) begin
      n_fail++;
      $display("FAIL b2b_first: cyc=%0d sum=%h, required cyc=5 sum=0123", cyc, sum_m);
    end
    // Still in the DONE cycle: this start must be accepted.
    a = 16'h9000; b = 16'h1000; mode = MODE_SUB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc);
    n_checks++;
    if (cyc != 5 || {sum_m, cout_m, ov_m, zero_m} !== {16'h8000, 3'b100}) begin
      n_fail++;
      $display("FAIL b2b_second: cyc=%0d sum=%h cvz=%b%b%b, required cyc=5 sum=8000 cvz=100",
               cyc, sum_m, cout_m, ov_m, zero_m);
    end
    $display("test_back_to_back: second result %h after %0d cycles", sum_m, cyc);
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    int spurious;
    launch(16'h0F0F, 16'h0101, MODE_ADD);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_m, done_m, sum_m, cout_m, ov_m, zero_m} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h c=%b v=%b z=%b, required all zero",
               busy_m, done_m, sum_m, cout_m, ov_m, zero_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_m !== 1'b0 || busy_m !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d cycles with activity, required 0", spurious);
    end
    launch(16'h0F0F, 16'h0101, MODE_ADD);
    wait_done(1, cyc);
    n_checks++;
    if (cyc != 5 || sum_m !== 16'h1010) begin
      n_fail++;
      $display("FAIL reset_recover: cyc=%0d sum=%h, required cyc=5 sum=1010", cyc, sum_m);
    end
    $display("test_reset_mid_run: recovered result %h", sum_m);
  endtask

  task automatic test_random_sweep;
    logic [15:0] ra, rb;
    logic        rm;
    int          sel;
    int          first_m, first_s, first_c, first_w;
    int          cnt_m, cnt_s, cnt_c, cnt_w;
    logic [18:0] exp16, exp8;
    int          errs;
    repeat (20) @(negedge clk);
    for (int it = 0; it < 1000; it++) begin
      ra  = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      rb  = (sel == 0) ? ra : (sel == 1) ? 16'(-ra) : 16'($urandom);
      rm  = 1'($urandom);
      exp16 = model(16, ra, rb, rm);
      exp8  = model(8, ra, rb, rm);
      first_m = 0; first_s = 0; first_c = 0; first_w = 0;
      cnt_m = 0; cnt_s = 0; cnt_c = 0; cnt_w = 0;
      launch(ra, rb, rm);
      for (int cyc = 1; cyc <= 19; cyc++) begin
        if (done_m === 1'b1) begin cnt_m++; if (first_m == 0) first_m = cyc; end
        if (done_s === 1'b1) begin cnt_s++; if (first_s == 0) first_s = cyc; end
        if (done_c === 1'b1) begin cnt_c++; if (first_c == 0) first_c = cyc; end
        if (done_w === 1'b1) begin cnt_w++; if (first_w == 0) first_w = cyc; end
        if (cyc < 19) @(negedge clk);
      end
      errs = 0;
      n_checks++;
      if (first_m != 5 || cnt_m != 1 || busy_m !== 1'b0 ||
          {sum_m, cout_m, ov_m, zero_m} !== exp16) begin
        n_fail++; errs++;
        $display("FAIL rand_d4 it=%0d %h%s%h: lat=%0d sum=%h cvz=%b%b%b, required lat=5 sum=%h cvz=%b",
                 it, ra, rm ? "-" : "+", rb, first_m, sum_m, cout_m, ov_m, zero_m,
                 exp16[18:3], exp16[2:0]);
      end
      n_checks++;
      if (first_s != 17 || cnt_s != 1 || busy_s !== 1'b0 ||
          {sum_s, cout_s, ov_s, zero_s} !== exp16) begin
        n_fail++; errs++;
        $display("FAIL rand_d1 it=%0d %h%s%h: lat=%0d sum=%h cvz=%b%b%b, required lat=17 sum=%h cvz=%b",
                 it, ra, rm ? "-" : "+", rb, first_s, sum_s, cout_s, ov_s, zero_s,
                 exp16[18:3], exp16[2:0]);
      end
      n_checks++;
      if (first_c != 2 || cnt_c != 1 || busy_c !== 1'b0 ||
          {sum_c, cout_c, ov_c, zero_c} !== exp16) begin
        n_fail++; errs++;
        $display("FAIL rand_d16 it=%0d %h%s%h: lat=%0d sum=%h cvz=%b%b%b, required lat=2 sum=%h cvz=%b",
                 it, ra, rm ? "-" : "+", rb, first_c, sum_c, cout_c, ov_c, zero_c,
                 exp16[18:3], exp16[2:0]);
      end
      n_checks++;
      if (first_w != 5 || cnt_w != 1 || busy_w !== 1'b0 ||
          {8'h00, sum_w, cout_w, ov_w, zero_w} !== exp8) begin
        n_fail++; errs++;
        $display("FAIL rand_w8 it=%0d %h%s%h: lat=%0d sum=%h cvz=%b%b%b, required lat=5 sum=%h cvz=%b",
                 it, ra[7:0], rm ? "-" : "+", rb[7:0], first_w, sum_w, cout_w, ov_w, zero_w,
                 exp8[10:3], exp8[2:0]);
      end
      $display("rand %0d: %h %s %h -> %h c=%b v=%b z=%b (%0d errors)",
               it, ra, rm ? "-" : "+", rb, exp16[18:3], exp16[2], exp16[1], exp16[0], errs);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_flags();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_addsub_gatelevel.md
Name: multicycle_addsub_gatelevel

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor for the computation datapath.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, through a registered carry.
- Uses a start/busy/done handshake and reports carry-out, signed overflow and a zero flag.
- Gives the ALU one configurable adder core that trades latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 gives bit-serial, WIDTH gives single-cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when accepted (see Behaviour).
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- sum  output  WIDTH  result; held until the next completion.
- cout  output  1  carry out of MSB; in subtract, 1 = no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Single clock, rst_n asynchronous active-low; all state registered.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0, zero=0; carry, digit counter and shift registers all 0.
- N = WIDTH/DIGIT. Elaboration error if WIDTH % DIGIT != 0 or DIGIT < 1.
- States:
  - IDLE: start=1 at edge -> latch a, b^{WIDTH{mode}}, carry=mode, count=0; go to RUN.
  - RUN: each edge adds the low DIGIT bits of the operand shift registers plus carry. It shifts the DIGIT-bit sum into the result shift register from the MSB side, updates carry and increments count. On the edge where count == N-1, it loads the outputs and goes to DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> accept as in IDLE and go to RUN. Otherwise go to IDLE.
- Handshake:
  - busy=1 in RUN only. start is ignored in RUN (no queueing, no restart).
  - Latency: start accepted at edge k -> done high in the cycle after edge k+N. Back-to-back issue yields one result every N+1 cycles.
- Arithmetic:
  - cout = final carry.
  - overflow = carry into MSB XOR carry out of MSB. This is captured on the last digit, from the DIGIT adder's internal MSB carry.
  - zero = (final sum == 0).
  - sum, cout, overflow and zero update only at the transition into DONE and hold through IDLE/RUN until the next completion.
- Boundaries:
  - Reset mid-RUN: the operation is aborted; all outputs return to reset values.
  - DIGIT=WIDTH: N=1, one RUN cycle.
  - Input changes on a/b/mode after acceptance have no effect.

Decomposition:
- Shared package: STATE_IDLE/STATE_RUN/STATE_DONE encodings (2-bit), MODE_ADD=0, MODE_SUB=1.
- Sub-module digit_adder_gatelevel:
  - Purely combinational DIGIT-bit ripple adder.
  - Built from the team's existing 1-bit gate-level full adder cells via generate.
  - Ports: a[DIGIT], b[DIGIT], cin; outputs sum[DIGIT], cout, c_msb (carry into MSB).
- Top holds the FSM, counter, operand/result shift registers and flag logic.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Add 0x1234+0x4321, start at edge 0 -> busy edges 1..4, done pulse after edge 4: sum=0x5555, cout=0, overflow=0, zero=0.
- Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, overflow=0, zero=1. Then 0x7FFF+0x0001 -> sum=0x8000, cout=0, overflow=1.
- Sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, overflow=0. Then 0x8000-0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- start pulsed mid-RUN with different operands -> ignored; the original result is produced. start held high in the DONE cycle -> the new op is accepted, and the next done follows N+1 cycles later.
- rst_n low for one cycle during RUN count=2 -> outputs go to zero immediately. After release there is no done until a new start; a new op then completes correctly.
- Parameter sweep DIGIT=1 (16 cycles), DIGIT=16 (1 cycle) and WIDTH=8/DIGIT=2, against 1000 random add/sub pairs checked against a behavioural model.
